// File: rtl/sigma_pkg.sv
// Shared types for the sigma execute-stage units: RV32M op encoding (funct3)
// and the multiply/divide sequencer states.
package sigma_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic op_signed_a(muldiv_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is signed for MULH, DIV, REM (MULHSU treats rs2 as unsigned)
  function automatic logic op_signed_b(muldiv_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/sigma_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference if it did not go negative.
module sigma_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so the XLEN+1-bit difference's MSB is a clean borrow flag
  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[XLEN];
  assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/sigma_muldiv.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Optional SIGMA_MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module sigma_muldiv
  import sigma_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_e       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state, state_next;
  muldiv_op_e        op_q;
  logic              sa_q, sb_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] acc;     // product, or {remainder, dividend/quotient}
  logic [2*XLEN-1:0] mcand;   // shifted multiplicand, or divisor in the low half
  logic [XLEN-1:0]   mplier;
  logic [CNT_W-1:0]  cnt;

  // Accept-time decode
  logic            accept, sa, sb, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_result;

  assign accept   = in_valid && (state == IDLE);
  assign sa       = op_signed_a(in_op) & in_a[XLEN-1];
  assign sb       = op_signed_b(in_op) & in_b[XLEN-1];
  assign mag_a    = sa ? -in_a : in_a;
  assign mag_b    = sb ? -in_b : in_b;
  assign div_zero = in_op[2] && (in_b == '0);
  assign div_ovf  = in_op[2] && op_signed_b(in_op) && (in_a == MIN_NEG) && (in_b == '1);
  assign special  = div_zero || div_ovf;
  // op[1] clear selects the quotient (DIV/DIVU), set selects the remainder
  assign special_result = div_zero ? (in_op[1] ? in_a : '1)
                                   : (in_op[1] ? '0   : in_a);

  // Per-iteration datapath
  logic [2*XLEN-1:0] prod_next, prod_signed;
  logic [XLEN-1:0]   rem_next, quot_next, quot_signed, rem_signed, mul_result, final_result;
  logic              q_bit, last;

  sigma_divstep #(.XLEN(XLEN)) u_divstep (
    .rem          (acc[2*XLEN-1:XLEN]),
    .dividend_bit (acc[XLEN-1]),
    .divisor      (mcand[XLEN-1:0]),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  assign prod_next   = acc + (mplier[0] ? mcand : '0);
  assign quot_next   = {acc[XLEN-2:0], q_bit};
  assign prod_signed = (sa_q ^ sb_q) ? -prod_next : prod_next;
  assign quot_signed = (sa_q ^ sb_q) ? -quot_next : quot_next;
  assign rem_signed  = sa_q ? -rem_next : rem_next;
  assign mul_result  = (op_q == MD_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
  assign final_result = op_q[2] ? (op_q[1] ? rem_signed : quot_signed) : mul_result;

`ifdef SIGMA_MULDIV_EARLY_OUT_EN
  assign last = op_q[2] ? (cnt == CNT_W'(XLEN-1)) : (mplier[XLEN-1:1] == '0);
`else
  assign last = (cnt == CNT_W'(XLEN-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_result <= '0;
      out_tag    <= '0;
      cnt        <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (special) begin
        out_result <= special_result;
        out_tag    <= in_tag;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        out_result <= final_result;
        out_tag    <= tag_q;
      end
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= in_op;
      tag_q  <= in_tag;
      sa_q   <= sa;
      sb_q   <= sb;
      acc    <= in_op[2] ? {{XLEN{1'b0}}, mag_a} : '0;
      mcand  <= {{XLEN{1'b0}}, (in_op[2] ? mag_b : mag_a)};
      mplier <= mag_b;
    end else if (state == BUSY) begin
      if (op_q[2]) begin
        acc <= {rem_next, quot_next};
      end else begin
        acc    <= prod_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: tb/tb_sigma_muldiv.sv
// Directed self-checking bench for sigma_muldiv: results, tags, latency,
// divide special cases, backpressure and mid-operation reset.
module tb_sigma_muldiv;
  import sigma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  muldiv_op_e  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SIGMA_MULDIV_EARLY_OUT_EN
  localparam int LAT_B5  = 3;
  localparam int LAT_B0  = 1;
  localparam int LAT_B16 = 17;
`else
  localparam int LAT_B5  = 32;
  localparam int LAT_B0  = 32;
  localparam int LAT_B16 = 32;
`endif

  sigma_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and check latency (edges after the accept edge), result and tag.
  task automatic run_op(input string name, input muldiv_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    check({name, "_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, out_result, exp_res);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_res;
    logic        spurious;
    rst = 1'b1; in_valid = 1'b0; in_op = MD_MUL; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_result",    out_result,     32'd0);
    check("rst_tag",       32'(out_tag),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mulh_min",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 32);
    run_op("mul_m1",     MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0001, 32);
    run_op("mulhsu_m1",  MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 32);
    run_op("mulhu_m1",   MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 32);
    run_op("divu_100_7", MD_DIVU,   32'd100,       32'd7,         5'd5,  32'd14,        32);
    run_op("remu_100_7", MD_REMU,   32'd100,       32'd7,         5'd6,  32'd2,         32);
    run_op("div_m7_2",   MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 32);
    run_op("rem_m7_2",   MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 32);
    run_op("div_by0",    MD_DIV,    32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 0);
    run_op("rem_by0",    MD_REM,    32'd5,         32'd0,         5'd10, 32'd5,         0);
    run_op("div_ovf",    MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
    run_op("rem_ovf",    MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         0);
    run_op("mul_3x5",    MD_MUL,    32'd3,         32'd5,         5'd13, 32'd15,        LAT_B5);
    run_op("mul_7x0",    MD_MUL,    32'd7,         32'd0,         5'd14, 32'd0,         LAT_B0);

    // Backpressure: result held, new requests ignored while out_valid && !out_ready.
    out_ready = 1'b0;
    run_op("bp_divu", MD_DIVU, 32'd1000, 32'd9, 5'd21, 32'd111, 32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = MD_MUL; in_a = 32'd2; in_b = 32'd2; in_tag = 5'd30;
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_ready_%0d", i), 32'(in_ready),  32'd0);
      check($sformatf("bp_res_%0d", i),   out_result,     32'd111);
      check($sformatf("bp_tag_%0d", i),   32'(out_tag),   32'd21);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ready", 32'(in_ready),  32'd1);
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_res",   out_result,     32'd111);
    check("bp_rel_tag",   32'(out_tag),   32'd21);
    run_op("bp_next", MD_REMU, 32'd1000, 32'd9, 5'd22, 32'd1, 32);

    // Reset in the middle of a DIVU: the operation is dropped.
    @(negedge clk);
    in_op = MD_DIVU; in_a = 32'hFFFF_FFFF; in_b = 32'd3; in_tag = 5'd23; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid",  32'(out_valid), 32'd0);
    check("mid_rst_ready",  32'(in_ready),  32'd1);
    check("mid_rst_busy",   32'(busy),      32'd0);
    check("mid_rst_result", out_result,     32'd0);
    check("mid_rst_tag",    32'(out_tag),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) spurious = 1'b1;
    end
    check("mid_rst_no_valid", 32'(spurious), 32'd0);
    held_res = out_result;
    check("mid_rst_res_idle", held_res, 32'd0);

    run_op("after_rst", MD_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd24, 32'd1, LAT_B16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
